// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one scratch SRAM between host and core ports.
// Optional grant counters are built when SRAM_ARB_STATS_EN is defined.
module sram_access_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 128,
    parameter int ADDR_LIMIT = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              h_req,
    input  logic              h_wr,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_err,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              c_req,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_err,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic [15:0]       h_gnt_cnt,
    output logic [15:0]       c_gnt_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA, ERR} state_t;

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(ADDR_LIMIT);

    state_t            state_q, state_d;
    logic              lw_core_q, lw_core_d;
    logic              win_core_q, win_core_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] h_rdata_q, h_rdata_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic              h_rvalid_q, h_rvalid_d;
    logic              c_rvalid_q, c_rvalid_d;

    logic              pick_core;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Winner selection: a tie goes to the side that did not win last time
    always_comb begin
        pick_core = c_req & (~h_req | ~lw_core_q);
        sel_wr    = pick_core ? c_wr    : h_wr;
        sel_addr  = pick_core ? c_addr  : h_addr;
        sel_wdata = pick_core ? c_wdata : h_wdata;
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            lw_core_q  <= 1'b1;
            win_core_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            h_rdata_q  <= '0;
            c_rdata_q  <= '0;
            h_rvalid_q <= 1'b0;
            c_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lw_core_q  <= lw_core_d;
            win_core_q <= win_core_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            h_rdata_q  <= h_rdata_d;
            c_rdata_q  <= c_rdata_d;
            h_rvalid_q <= h_rvalid_d;
            c_rvalid_q <= c_rvalid_d;
        end
    end

    // Next state; the SRAM address/data only move when an access is launched
    always_comb begin
        state_d    = state_q;
        lw_core_d  = lw_core_q;
        win_core_d = win_core_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        h_rdata_d  = h_rdata_q;
        c_rdata_d  = c_rdata_q;
        h_rvalid_d = 1'b0;
        c_rvalid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (h_req | c_req) begin
                    win_core_d = pick_core;
                    lw_core_d  = pick_core;
                    wr_d       = sel_wr;
                    if (sel_addr >= LIMIT) begin
                        state_d = ERR;
                    end else begin
                        state_d = ACCESS;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                    end
                end
            end
            ACCESS: state_d = wr_q ? IDLE : RDATA;
            RDATA: begin
                state_d = IDLE;
                if (win_core_q) begin
                    c_rdata_d  = read_data;
                    c_rvalid_d = 1'b1;
                end else begin
                    h_rdata_d  = read_data;
                    h_rvalid_d = 1'b1;
                end
            end
            ERR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state and latched command
    always_comb begin
        read       = (state_q == ACCESS) & ~wr_q;
        write      = (state_q == ACCESS) & wr_q;
        h_gnt      = (state_q == ACCESS) & ~win_core_q;
        c_gnt      = (state_q == ACCESS) & win_core_q;
        h_err      = (state_q == ERR) & ~win_core_q;
        c_err      = (state_q == ERR) & win_core_q;
        busy       = (state_q != IDLE);
        addr       = addr_q;
        write_data = wdata_q;
        h_rdata    = h_rdata_q;
        c_rdata    = c_rdata_q;
        h_rvalid   = h_rvalid_q;
        c_rvalid   = c_rvalid_q;
    end

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] h_cnt_q, h_cnt_d;
    logic [15:0] c_cnt_q, c_cnt_d;

    // Saturating grant counters
    always_comb begin
        h_cnt_d = h_cnt_q;
        c_cnt_d = c_cnt_q;
        if (h_gnt && h_cnt_q != 16'hFFFF) h_cnt_d = h_cnt_q + 16'd1;
        if (c_gnt && c_cnt_q != 16'hFFFF) c_cnt_d = c_cnt_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            h_cnt_q <= '0;
            c_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            c_cnt_q <= c_cnt_d;
        end
    end

    assign h_gnt_cnt = h_cnt_q;
    assign c_gnt_cnt = c_cnt_q;
`else
    assign h_gnt_cnt = 16'd0;
    assign c_gnt_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter with a behavioural SRAM.
// Host uses even addresses, core odd ones, so each port's data is private.
module tb_sram_access_arbiter;

    localparam int K_GNT = 0;
    localparam int K_RV  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int           kind;
        bit           w;
        logic [15:0]  a;
        logic [127:0] d;
    } exp_t;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         req [2];
    logic         wr  [2];
    logic [15:0]  ad  [2];
    logic [127:0] wd  [2];
    logic         gnt [2];
    logic         err [2];
    logic         rv  [2];
    logic [127:0] rd  [2];
    logic         read, write, busy;
    logic [15:0]  addr;
    logic [127:0] write_data;
    logic [127:0] read_data = '0;
    logic [15:0]  h_gnt_cnt, c_gnt_cnt;

    logic [127:0] mem     [64] = '{default: '0};
    logic [127:0] ref_mem [64] = '{default: '0};

    exp_t q0[$];
    exp_t q1[$];
    int   gnt_log[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sram_access_arbiter dut (
        .clk(clk), .n_rst(n_rst),
        .h_req(req[0]), .h_wr(wr[0]), .h_addr(ad[0]), .h_wdata(wd[0]),
        .h_gnt(gnt[0]), .h_err(err[0]), .h_rvalid(rv[0]), .h_rdata(rd[0]),
        .c_req(req[1]), .c_wr(wr[1]), .c_addr(ad[1]), .c_wdata(wd[1]),
        .c_gnt(gnt[1]), .c_err(err[1]), .c_rvalid(rv[1]), .c_rdata(rd[1]),
        .read(read), .write(write), .addr(addr), .write_data(write_data),
        .read_data(read_data), .busy(busy),
        .h_gnt_cnt(h_gnt_cnt), .c_gnt_cnt(c_gnt_cnt)
    );

    // Behavioural SRAM: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (write && addr < 16'd64) mem[addr[5:0]] <= write_data;
        if (read) read_data <= (addr < 16'd64) ? mem[addr[5:0]] : '0;
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int p, input exp_t e);
        if (p == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon(input int p);
        exp_t x;
        int   k;
        if (gnt[p] || err[p] || rv[p]) begin
            if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse port%0d g=%b e=%b v=%b",
                         p, gnt[p], err[p], rv[p]);
            end else begin
                x = (p == 0) ? q0.pop_front() : q1.pop_front();
                k = gnt[p] ? K_GNT : (err[p] ? K_ERR : K_RV);
                chk($sformatf("kind_p%0d", p), 128'(k), 128'(x.kind));
                if (gnt[p]) begin
                    gnt_log.push_back(p);
                    chk("strobe", {126'd0, read, write},
                        x.w ? 128'd1 : 128'd2);
                    chk("addr", 128'(addr), 128'(x.a));
                    if (x.w) chk("write_data", write_data, x.d);
                end
                if (err[p]) chk("err_no_strobe", {126'd0, read, write}, 128'd0);
                if (rv[p]) chk($sformatf("rdata_p%0d", p), rd[p], x.d);
                if (gnt[p] || err[p]) chk("busy", 128'(busy), 128'd1);
            end
        end
    endtask

    // Monitor: pop the scoreboard whenever a port shows a response
    always @(negedge clk) begin
        if (read && write) chk("two_strobes", 128'd1, 128'd0);
        mon(0);
        mon(1);
    end

    task automatic do_op(input int p, input bit w, input logic [15:0] a,
                         input logic [127:0] d);
        exp_t e;
        int   n;
        e.w = w;
        e.a = a;
        e.d = d;
        if (a >= 16'd64) begin
            e.kind = K_ERR;
            push(p, e);
        end else begin
            e.kind = K_GNT;
            push(p, e);
            if (w) begin
                ref_mem[a[5:0]] = d;
            end else begin
                e.kind = K_RV;
                e.d = ref_mem[a[5:0]];
                push(p, e);
            end
        end
        @(negedge clk);
        req[p] = 1'b1;
        wr[p]  = w;
        ad[p]  = a;
        wd[p]  = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt[p] || err[p]) && n < 6);
        chk($sformatf("wait_bound_p%0d", p), 128'(gnt[p] | err[p]), 128'd1);
        req[p] = 1'b0;
    endtask

    task automatic rand_op(input int p);
        logic [15:0]  a;
        logic [127:0] d;
        bit           w;
        w = 1'($urandom % 2);
        d = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom % 8 == 0) begin
            case ($urandom % 3)
                0: a = 16'd64;
                1: a = 16'hFFFF;
                default: a = 16'($urandom_range(65, 65535));
            endcase
        end else begin
            a = 16'(($urandom % 32) * 2 + p);
        end
        do_op(p, w, a, d);
        repeat ($urandom % 3) @(negedge clk);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        exp_t e;
        int   n;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0;
            wr[i]  = 1'b0;
            ad[i]  = '0;
            wd[i]  = '0;
        end
        do_reset();
        chk("reset_idle", {122'd0, read, write, busy, gnt[0], gnt[1], rv[0]},
            128'd0);
        chk("reset_addr", {addr, write_data[111:0]}, 128'd0);

        // Simultaneous requests from reset: host, core, then host again
        gnt_log.delete();
        fork
            begin
                do_op(0, 1'b0, 16'd0, '0);
                do_op(0, 1'b0, 16'd0, '0);
            end
            do_op(1, 1'b0, 16'd0, '0);
        join
        repeat (4) @(negedge clk);
        chk("rr_count", 128'(gnt_log.size()), 128'd3);
        if (gnt_log.size() == 3) begin
            chk("rr_first",  128'(gnt_log[0]), 128'd0);
            chk("rr_second", 128'(gnt_log[1]), 128'd1);
            chk("rr_third",  128'(gnt_log[2]), 128'd0);
        end

        do_op(0, 1'b1, 16'd0, 128'h09CF4F3C_ABF71588_28AED2A6_2B7E1516);
        do_op(0, 1'b1, 16'd32, 128'hAAF43DDD_A22100EF_8766450A_B4321176);
        do_op(0, 1'b0, 16'd32, '0);
        do_op(0, 1'b0, 16'd64, '0);
        do_op(1, 1'b0, 16'd65, '0);
        repeat (4) @(negedge clk);

        fork
            for (int i = 0; i < 120; i++) rand_op(0);
            for (int j = 0; j < 120; j++) rand_op(1);
        join
        repeat (4) @(negedge clk);

        // Reset while a core read sits in RDATA
        e.kind = K_GNT;
        e.w = 1'b0;
        e.a = 16'd1;
        e.d = '0;
        push(1, e);
        @(negedge clk);
        req[1] = 1'b1;
        wr[1]  = 1'b0;
        ad[1]  = 16'd1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[1] && n < 6);
        chk("abort_gnt", 128'(gnt[1]), 128'd1);
        req[1] = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        chk("abort_ctrl", {120'd0, read, write, busy, gnt[0], gnt[1],
                           err[0], err[1], rv[1]}, 128'd0);
        chk("abort_addr", 128'(addr), 128'd0);
        chk("abort_wdata", write_data, 128'd0);
        chk("abort_rdata", rd[0] | rd[1], 128'd0);
        n_rst = 1'b1;
        do_op(1, 1'b0, 16'd3, '0);
        repeat (4) @(negedge clk);

        do_reset();
        do_op(0, 1'b1, 16'd2, 128'h11);
        do_op(1, 1'b1, 16'd5, 128'h22);
        do_op(0, 1'b0, 16'd2, '0);
        do_op(0, 1'b0, 16'hFFFF, '0);
        do_op(1, 1'b0, 16'd5, '0);
        do_op(0, 1'b1, 16'd4, 128'h33);
        repeat (4) @(negedge clk);
`ifdef SRAM_ARB_STATS_EN
        chk("h_gnt_cnt", 128'(h_gnt_cnt), 128'd3);
        chk("c_gnt_cnt", 128'(c_gnt_cnt), 128'd2);
`else
        chk("h_gnt_cnt", 128'(h_gnt_cnt), 128'd0);
        chk("c_gnt_cnt", 128'(c_gnt_cnt), 128'd0);
`endif
        chk("sb_drained", 128'(q0.size() + q1.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
